// File: rtl/icache_fetch_ctrl_pkg.sv
// rtl/icache_fetch_ctrl_pkg.sv - shared types and constants for the fetch sequencer
// Purpose: FSM state encoding, instruction width, default fetch parameters.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam int          INSTR_W        = 16;
  localparam int          ADDR_W_DEF     = 32;
  localparam int          FIFO_DEPTH_DEF = 2;
  localparam logic [31:0] RESET_PC_DEF   = 32'd0;

endpackage

// File: rtl/icache_fetch_ctrl_if.sv
// rtl/icache_fetch_ctrl_if.sv - fetch sequencer bus: control, ICache port, decode port
// Purpose: bundles every non-clock/reset signal of icache_fetch_ctrl.
// Ports (master = fetch controller view):
//   redirect_valid/redirect_index/halt  in   control from the pipeline
//   ic_not_enable/ic_index              out  ICache read request
//   ic_data                             in   ICache read data, one cycle after a request
//   instr_valid/instr_data/instr_index  out  decode stream
//   instr_ready                         in   decode accept
interface icache_fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = INSTR_W
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_index;
  logic              halt;
  logic              ic_not_enable;
  logic [ADDR_W-1:0] ic_index;
  logic [DATA_W-1:0] ic_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_index;

  modport master (
    input  redirect_valid, redirect_index, halt, ic_data, instr_ready,
    output ic_not_enable, ic_index, instr_valid, instr_data, instr_index
  );

  modport slave (
    output redirect_valid, redirect_index, halt, ic_data, instr_ready,
    input  ic_not_enable, ic_index, instr_valid, instr_data, instr_index
  );
endinterface

// File: rtl/icache_fetch_ctrl_fifo.sv
// rtl/icache_fetch_ctrl_fifo.sv - small synchronous FIFO with flush and occupancy count
// Purpose: buffers {instruction, index} between the ICache and decode.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_flush         synchronous clear; wins over push and pop
//   i_push/i_push_data  write an entry
//   i_pop           remove the head entry (ignored when empty)
//   o_head_data     head entry, zero when empty
//   o_count         current number of entries
module fetch_fifo #(
  parameter  int WIDTH = 48,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_do_pop = i_pop & (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_do_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count     = r_count;
endmodule

// File: rtl/icache_fetch_ctrl.sv
// rtl/icache_fetch_ctrl.sv - instruction fetch sequencer in front of the ICache
// Purpose: owns the fetch index, issues ICache reads under a credit limit, absorbs the
// one-cycle read latency in fetch_fifo and streams {instr, index} to decode; handles
// redirect (flush + restart) and halt.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        icache_fetch_ctrl_if.master (control, ICache port, decode port)
module icache_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DATA_W     = INSTR_W,
  parameter int                FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  icache_fetch_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_tag;
  logic                r_inflight;
  logic                w_issue;
  logic                w_pop;
  logic                w_push;
  logic                w_credit_ok;
  logic [CNT_W-1:0]    w_count;
  logic [DATA_W+ADDR_W-1:0] w_head;

  assign w_pop = bus.instr_valid & bus.instr_ready;

  // Entries held plus the read in flight, less the one leaving this cycle, must stay
  // below the depth so the returning read always has a slot. Written with the pop on
  // the right-hand side to avoid an unsigned underflow.
  assign w_credit_ok = (32'(w_count) + 32'(r_inflight)) < (32'(FIFO_DEPTH) + 32'(w_pop));

  // A read that returns in a redirect cycle belongs to the old stream and is dropped.
  assign w_push = r_inflight & ~bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = ST_FETCH;
      ST_FETCH:  w_state_nxt = bus.halt ? ST_HALTED : ST_FETCH;
      ST_HALTED: w_state_nxt = bus.halt ? ST_HALTED : ST_FETCH;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_issue = 1'b0;
    if (r_state == ST_FETCH) begin
      w_issue = ~bus.halt & ~bus.redirect_valid & w_credit_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (bus.redirect_valid) r_fetch_pc <= bus.redirect_index;
      else if (w_issue)       r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      if (w_issue) r_tag <= r_fetch_pc;
      r_inflight <= w_issue;
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (bus.redirect_valid),
    .i_push      (w_push),
    .i_push_data ({bus.ic_data, r_tag}),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_count     (w_count)
  );

  assign bus.ic_not_enable = ~w_issue;
  assign bus.ic_index      = r_fetch_pc;
  assign bus.instr_valid   = (w_count != '0);
  assign bus.instr_data    = w_head[DATA_W+ADDR_W-1:ADDR_W];
  assign bus.instr_index   = w_head[ADDR_W-1:0];
endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// tb/tb_icache_fetch_ctrl.sv - scoreboard bench for icache_fetch_ctrl
module tb_icache_fetch_ctrl;
  import fetch_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  icache_fetch_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] mem_of(input logic [AW-1:0] i);
    return 16'(16'hA000 + i[15:0]);
  endfunction

  // ICache model: synchronous one-cycle read, zero when not enabled.
  always @(posedge clk) begin
    bus.ic_data <= bus.ic_not_enable ? '0 : mem_of(bus.ic_index);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;
  int occ   = 0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] m_next;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: the delivered stream is the sequential index run starting at the last
  // restart point; data is the ICache content of that index.
  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(m_next);
      m_next = m_next + 1;
    end
  endtask

  task automatic model_restart(input logic [AW-1:0] start);
    exp_q.delete();
    m_next = start;
    occ = 0;
    refill();
  endtask

  // Monitor: compare every accepted instruction with the scoreboard head and bound the
  // number of outstanding reads (buffered plus in flight).
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.instr_valid && bus.instr_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(1), 64'(0));
        end else begin
          logic [AW-1:0] e;
          e = exp_q.pop_front();
          check("instr_index", 64'(bus.instr_index), 64'(e));
          check("instr_data", 64'(bus.instr_data), 64'(mem_of(e)));
          refill();
        end
        occ--;
      end
      if (!bus.ic_not_enable) occ++;
      check("occupancy_le_depth", 64'(occ <= DEPTH), 64'(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [AW-1:0] idx);
    bus.redirect_valid = 1'b1;
    bus.redirect_index = idx;
    @(negedge clk);
    #1 model_restart(idx);
    @(posedge clk);
    #1 bus.redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.halt = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_index = '0;
    bus.instr_ready = 1'b1;
    model_restart('0);

    // 1 reset and first fill
    tick();
    check("rst_ic_not_enable", 64'(bus.ic_not_enable), 64'(1));
    check("rst_instr_valid", 64'(bus.instr_valid), 64'(0));
    check("rst_instr_data", 64'(bus.instr_data), 64'(0));
    check("rst_instr_index", 64'(bus.instr_index), 64'(0));
    check("rst_ic_index", 64'(bus.ic_index), 64'(0));
    tick();
    check("rst_ic_not_enable2", 64'(bus.ic_not_enable), 64'(1));
    rst = 1'b0;
    tick();
    check("first_issue", 64'(bus.ic_not_enable), 64'(0));
    check("fill_valid0", 64'(bus.instr_valid), 64'(0));
    tick();
    check("fill_valid1", 64'(bus.instr_valid), 64'(0));
    tick();
    check("fill_valid2", 64'(bus.instr_valid), 64'(1));
    check("first_index", 64'(bus.instr_index), 64'(0));

    // 2 backpressure at index 10 (also checks one-per-cycle delivery on the way)
    for (int k = 0; k < 30 && !(bus.instr_valid && bus.instr_index == 10); k++) begin
      check("stream_no_bubble", 64'(bus.instr_valid), 64'(1));
      tick();
    end
    check("reach_index10", 64'(bus.instr_index), 64'(10));
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_head_held", 64'(bus.instr_index), 64'(10));
    end
    check("bp_full_no_issue", 64'(bus.ic_not_enable), 64'(1));
    check("bp_valid", 64'(bus.instr_valid), 64'(1));
    bus.instr_ready = 1'b1;
    repeat (8) tick();

    // 3 redirect to 0x100 mid-stream
    check("pre_redir_valid", 64'(bus.instr_valid), 64'(1));
    do_redirect(32'h100);
    check("redir_valid_clr", 64'(bus.instr_valid), 64'(0));
    for (int k = 0; k < 6 && !bus.instr_valid; k++) tick();
    check("redir_first_index", 64'(bus.instr_index), 64'(32'h100));
    repeat (8) tick();

    // 4 halt for 4 cycles
    bus.halt = 1'b1;
    #1 check("halt_no_issue0", 64'(bus.ic_not_enable), 64'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("halt_no_issue", 64'(bus.ic_not_enable), 64'(1));
    end
    tick();
    bus.halt = 1'b0;
    repeat (8) tick();

    // 5 wrap
    do_redirect(32'hFFFF_FFFF);
    repeat (8) tick();

    // 6 reset pulse mid-stream
    check("pre_rst_valid", 64'(bus.instr_valid), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    #1 model_restart('0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_pulse_valid_clr", 64'(bus.instr_valid), 64'(0));
    repeat (10) tick();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.halt = ~bus.halt;
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) do_redirect($urandom());
        else do_redirect(32'hFFFF_FFFF - $urandom_range(0, 3));
      end else begin
        tick();
      end
    end
    bus.halt = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (12) tick();
    check("progress", 64'(n_pop > 100), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
